// File: rtl/apb_regfile_slave.sv
// APB completer with a bank of NUMREGS word registers.
// Register 0 is exported as a control word (o_CTRL); the top index is a
// read-only status word taken from i_RO_DATA. Every access phase is
// stretched by WAITSTATES wait cycles before PREADY is returned.
// Optional feature: define APB_SLVERR_EN to flag unaligned, out-of-range
// and read-only-write accesses on o_PSLVERR (tied low otherwise).
module apb_regfile_slave #(
  parameter int PADDRWIDTH = 32,
  parameter int DATAWIDTH  = 32,
  parameter int NUMREGS    = 16,
  parameter int WAITSTATES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    i_PSEL,
  input  logic [PADDRWIDTH-1:0]   i_PADDR,
  input  logic                    i_PENABLE,
  input  logic                    i_PWRITE,
  input  logic [DATAWIDTH-1:0]    i_PWDATA,
  input  logic [DATAWIDTH/8-1:0]  i_PSTRB,
  input  logic                    i_PPROT,
  input  logic [DATAWIDTH-1:0]    i_RO_DATA,
  output logic                    o_PREADY,
  output logic [DATAWIDTH-1:0]    o_PRDATA,
  output logic                    o_PSLVERR,
  output logic [DATAWIDTH-1:0]    o_CTRL
);

  localparam int NBYTES = DATAWIDTH / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int IDXW   = $clog2(NUMREGS);
  localparam logic [IDXW-1:0]       RO_IDX   = IDXW'(NUMREGS - 1);
  localparam logic [PADDRWIDTH-1:0] LOW_MASK = ~({PADDRWIDTH{1'b1}} << LSB);
  localparam logic [3:0]            WS_LOAD  = 4'(WAITSTATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]            wait_cnt;
  logic [PADDRWIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [DATAWIDTH-1:0]  cap_wdata;
  logic [NBYTES-1:0]     cap_strb;
  logic [DATAWIDTH-1:0]  regs [NUMREGS];

  logic                  setup_accept;
  logic [PADDRWIDTH-1:0] dec_addr;
  logic                  dec_write;
  logic [IDXW-1:0]       dec_idx;
  logic                  dec_invalid;
  logic                  dec_ro;
  logic                  enter_ready;
  logic                  commit;
  logic [DATAWIDTH-1:0]  read_val;

  // PPROT carries no meaning for this register bank.
  logic unused_pprot;
  assign unused_pprot = i_PPROT;

  // With zero wait states the completion edge is the setup edge itself, so
  // decoding looks at the live bus then and at the captured copy afterwards.
  assign setup_accept = (state == S_IDLE) && i_PSEL && !i_PENABLE;
  assign dec_addr     = setup_accept ? i_PADDR  : cap_addr;
  assign dec_write    = setup_accept ? i_PWRITE : cap_write;
  assign dec_idx      = dec_addr[LSB +: IDXW];
  assign dec_invalid  = ((dec_addr & LOW_MASK) != '0) ||
                        ((dec_addr >> (LSB + IDXW)) != '0);
  assign dec_ro       = (dec_idx == RO_IDX);
  assign enter_ready  = (state_next == S_READY);
  assign commit       = (state == S_READY) && dec_write && !dec_invalid && !dec_ro;
  assign o_CTRL       = regs[0];

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic: setup -> optional wait cycles -> one ready cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (setup_accept) state_next = (WAITSTATES == 0) ? S_READY : S_WAIT;
      end
      S_WAIT: begin
        if (!i_PSEL)               state_next = S_IDLE;
        else if (wait_cnt <= 4'd1) state_next = S_READY;
      end
      S_READY: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Capture the transfer at setup and count down the wait cycles.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt  <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
    end else if (setup_accept) begin
      wait_cnt  <= WS_LOAD;
      cap_addr  <= i_PADDR;
      cap_write <= i_PWRITE;
      cap_wdata <= i_PWDATA;
      cap_strb  <= i_PSTRB;
    end else if (state == S_WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Read mux: invalid addresses read zero, the top index is live status.
  always_comb begin
    read_val = '0;
    if (!dec_invalid) read_val = dec_ro ? i_RO_DATA : regs[dec_idx];
  end

  // Register bank: byte-strobed write commits at the end of the ready cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUMREGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (cap_strb[k]) regs[dec_idx][k*8 +: 8] <= cap_wdata[k*8 +: 8];
      end
    end
  end

  // Registered completion: PREADY and PRDATA only live in the ready cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      o_PREADY <= 1'b0;
      o_PRDATA <= '0;
    end else begin
      o_PREADY <= enter_ready;
      o_PRDATA <= (enter_ready && !dec_write) ? read_val : '0;
    end
  end

`ifdef APB_SLVERR_EN
  // Error flag raised alongside PREADY for bad addresses and read-only writes.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) o_PSLVERR <= 1'b0;
    else          o_PSLVERR <= enter_ready && (dec_invalid || (dec_write && dec_ro));
  end
`else
  assign o_PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave (default parameters: 32-bit bus,
// 16 registers, 2 wait states). Expected completions are queued when a
// transfer is issued and checked when PREADY appears; a reference register
// model supplies read data and o_CTRL values.
module tb_apb_regfile_slave;

  localparam int WS = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        i_PSEL;
  logic [31:0] i_PADDR;
  logic        i_PENABLE;
  logic        i_PWRITE;
  logic [31:0] i_PWDATA;
  logic [3:0]  i_PSTRB;
  logic        i_PPROT;
  logic [31:0] i_RO_DATA;
  logic        o_PREADY;
  logic [31:0] o_PRDATA;
  logic        o_PSLVERR;
  logic [31:0] o_CTRL;

  int          n_vec = 0;
  int          n_miscmp = 0;
  logic [31:0] model [16];
  exp_t        sb [$];

  apb_regfile_slave #(
    .PADDRWIDTH(32), .DATAWIDTH(32), .NUMREGS(16), .WAITSTATES(WS)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .i_PSEL(i_PSEL), .i_PADDR(i_PADDR),
    .i_PENABLE(i_PENABLE), .i_PWRITE(i_PWRITE), .i_PWDATA(i_PWDATA),
    .i_PSTRB(i_PSTRB), .i_PPROT(i_PPROT), .i_RO_DATA(i_RO_DATA),
    .o_PREADY(o_PREADY), .o_PRDATA(o_PRDATA), .o_PSLVERR(o_PSLVERR),
    .o_CTRL(o_CTRL)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic addr_invalid(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:6] != 26'd0);
  endfunction

  function automatic logic exp_err(input logic wr, input logic [31:0] a);
`ifdef APB_SLVERR_EN
    return addr_invalid(a) || (wr && a[5:2] == 4'hF);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  // One complete APB transfer starting at the next falling edge; returns in
  // the ready cycle with the bus still in its access phase.
  task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    int   cyc;
    logic [3:0] idx;
    idx = addr[5:2];
    e.rdata = 32'h0;
    if (!wr && !addr_invalid(addr)) e.rdata = (idx == 4'hF) ? i_RO_DATA : model[idx];
    e.err = exp_err(wr, addr);
    sb.push_back(e);

    @(negedge PCLK);
    i_PSEL = 1'b1; i_PENABLE = 1'b0; i_PADDR = addr;
    i_PWRITE = wr; i_PWDATA = data; i_PSTRB = strb;
    @(negedge PCLK);
    i_PENABLE = 1'b1;
    cyc = 1;
    if (!o_PREADY) checkOutput({tag, "_prdata_wait"}, o_PRDATA, 32'h0);
    while (!o_PREADY && cyc < 20) begin
      @(negedge PCLK);
      cyc++;
    end
    checkOutput({tag, "_ready"}, {31'd0, o_PREADY}, 32'd1);
    e = sb.pop_front();
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(WS + 1));
    checkOutput({tag, "_prdata"}, o_PRDATA, e.rdata);
    checkOutput({tag, "_pslverr"}, {31'd0, o_PSLVERR}, {31'd0, e.err});
    if (wr && !addr_invalid(addr) && idx != 4'hF) begin
      checkOutput({tag, "_ctrl_hold"}, o_CTRL, model[0]);
      for (int k = 0; k < 4; k++)
        if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
    end
  endtask

  task automatic idleCycle();
    @(negedge PCLK);
    i_PSEL = 1'b0; i_PENABLE = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0; i_PSEL = 1'b0; i_PADDR = '0; i_PENABLE = 1'b0;
    i_PWRITE = 1'b0; i_PWDATA = '0; i_PSTRB = '0; i_PPROT = 1'b0;
    i_RO_DATA = 32'h0;
    modelReset();
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;

    // Reset state and idle bus
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      checkOutput("idle_pready", {31'd0, o_PREADY}, 32'd0);
    end
    checkOutput("rst_prdata", o_PRDATA, 32'h0);
    checkOutput("rst_pslverr", {31'd0, o_PSLVERR}, 32'd0);
    checkOutput("rst_ctrl", o_CTRL, 32'h0);

    // Full-word write to register 0, then byte-strobed overwrite
    applyStimulus("wr0_full", 1'b1, 32'h0, 32'hDEADCAFE, 4'hF);
    idleCycle();
    checkOutput("ctrl_full", o_CTRL, 32'hDEADCAFE);
    applyStimulus("wr0_strb", 1'b1, 32'h0, 32'h11223344, 4'b0101);
    idleCycle();
    checkOutput("ctrl_strb", o_CTRL, 32'hDE22CA44);
    applyStimulus("rd0", 1'b0, 32'h0, 32'hFFFFFFFF, 4'hF);
    idleCycle();

    // Read-only status index
    i_RO_DATA = 32'hFEEA0123;
    applyStimulus("rd_ro", 1'b0, 32'h3C, 32'h0, 4'h0);
    idleCycle();
    applyStimulus("wr_ro", 1'b1, 32'h3C, 32'h5, 4'hF);
    idleCycle();
    applyStimulus("rd_ro2", 1'b0, 32'h3C, 32'h0, 4'h0);
    idleCycle();

    // Out-of-range and unaligned accesses
    applyStimulus("rd_oor", 1'b0, 32'h40, 32'h0, 4'h0);
    idleCycle();
    applyStimulus("rd_unal", 1'b0, 32'h2, 32'h0, 4'h0);
    idleCycle();
    applyStimulus("wr_oor", 1'b1, 32'h44, 32'hCAFEF00D, 4'hF);
    idleCycle();
    applyStimulus("rd1_after_oor", 1'b0, 32'h4, 32'h0, 4'h0);
    idleCycle();
    applyStimulus("wr_unal", 1'b1, 32'h1, 32'h0BADBEEF, 4'hF);
    idleCycle();
    checkOutput("ctrl_after_unal", o_CTRL, 32'hDE22CA44);

    // PSEL dropped during wait states: transfer abandoned without effect
    @(negedge PCLK);
    i_PSEL = 1'b1; i_PENABLE = 1'b0; i_PADDR = 32'h4;
    i_PWRITE = 1'b1; i_PWDATA = 32'h12345678; i_PSTRB = 4'hF;
    @(negedge PCLK);
    i_PENABLE = 1'b1;
    @(negedge PCLK);
    i_PSEL = 1'b0; i_PENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      checkOutput("abort_pready", {31'd0, o_PREADY}, 32'd0);
    end
    applyStimulus("rd1_after_abort", 1'b0, 32'h4, 32'h0, 4'h0);

    // Back-to-back write then read, no idle cycle in between
    applyStimulus("b2b_wr", 1'b1, 32'h8, 32'hA5A55A5A, 4'hF);
    applyStimulus("b2b_rd", 1'b0, 32'h8, 32'h0, 4'h0);

    // Reset pulsed while a third write sits in its wait states
    @(negedge PCLK);
    i_PSEL = 1'b1; i_PENABLE = 1'b0; i_PADDR = 32'h8;
    i_PWRITE = 1'b1; i_PWDATA = 32'hFFFFFFFF; i_PSTRB = 4'hF;
    @(negedge PCLK);
    i_PENABLE = 1'b1;
    PRESETn = 1'b0;
    #1;
    checkOutput("rstmid_pready", {31'd0, o_PREADY}, 32'd0);
    checkOutput("rstmid_prdata", o_PRDATA, 32'h0);
    checkOutput("rstmid_pslverr", {31'd0, o_PSLVERR}, 32'd0);
    checkOutput("rstmid_ctrl", o_CTRL, 32'h0);
    modelReset();
    @(negedge PCLK);
    i_PSEL = 1'b0; i_PENABLE = 1'b0;
    PRESETn = 1'b1;
    applyStimulus("rd2_after_rst", 1'b0, 32'h8, 32'h0, 4'h0);
    idleCycle();
    applyStimulus("rd0_after_rst", 1'b0, 32'h0, 32'h0, 4'h0);
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
